// File: rtl/enemy_pkg.sv
// enemy_pkg: shared types and helpers for the enemy behaviour controller
package enemy_pkg;
  typedef enum logic [2:0] {DIR_STOP, DIR_LEFT, DIR_RIGHT, DIR_DOWN, DIR_UP} dir_t;
  typedef enum logic [1:0] {ET_NONE, ET_KEESE, ET_REDEAD, ET_SLIDER} etype_t;
  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic dir_t reverse_dir(input dir_t d);
    return d == DIR_LEFT ? DIR_RIGHT : d == DIR_RIGHT ? DIR_LEFT :
           d == DIR_DOWN ? DIR_UP : d == DIR_UP ? DIR_DOWN : DIR_STOP;
  endfunction
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR that advances one step whenever step is high
module lfsr16
  import enemy_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  logic [15:0] value_q, value_d;
  always_comb value_d = step ? lfsr_next(value_q) : value_q;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) value_q <= seed;
    else value_q <= value_d;
  assign value = value_q;
endmodule

// File: rtl/enemy_ai_ctrl.sv
// enemy_ai_ctrl: per-enemy behaviour controller driving an Enemy's dir and initialize inputs
module enemy_ai_ctrl
  import enemy_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          HOLD_FRAMES = 32,
  parameter int          INIT_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [2:0] room,
  input  logic       active,
  input  logic [1:0] Enemy_Type,
  input  logic [9:0] Enemy_X,
  input  logic [9:0] Enemy_Y,
  input  logic [9:0] Player_X,
  input  logic [9:0] Player_Y,
  output logic [2:0] dir,
  output logic       initialize
);
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  localparam int IW = $clog2(INIT_FRAMES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_FRAMES - 1);
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
  state_t        state_q, state_d;
  dir_t          dir_q, dir_d, pick, chase;
  etype_t        etype;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    guard_q, guard_d;
  logic [2:0]    room_q;
  logic          room_vld_q, frame_clk_q, initialize_q, initialize_d;
  logic [9:0]    last_x_q, last_x_d, last_y_q, last_y_d;
  logic [10:0]   dx, dy, adx, ady;
  logic [15:0]   lfsr_val;
  logic [1:0]    lfsr_lo;
  logic          fe, room_chg, stall, lfsr_step;
  assign fe       = frame_clk & ~frame_clk_q;
  assign room_chg = room_vld_q & (room != room_q);
  assign stall    = guard_q == 2'd0 && dir_q != DIR_STOP && Enemy_X == last_x_q && Enemy_Y == last_y_q;
  lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .step    (lfsr_step),
    .seed    (SEED_NZ),
    .value   (lfsr_val)
  );
  // Candidate direction for a timer pick; the Keese value uses the LFSR state after this step.
  always_comb begin
    etype   = etype_t'(Enemy_Type);
    dx      = {1'b0, Player_X} - {1'b0, Enemy_X};
    dy      = {1'b0, Player_Y} - {1'b0, Enemy_Y};
    adx     = dx[10] ? -dx : dx;
    ady     = dy[10] ? -dy : dy;
    chase   = (dx == '0 && dy == '0) ? DIR_STOP :
              (adx >= ady) ? (dx[10] ? DIR_LEFT : DIR_RIGHT) : (dy[10] ? DIR_UP : DIR_DOWN);
    lfsr_lo = 2'(lfsr_next(lfsr_val));
    pick    = etype == ET_KEESE  ? dir_t'({1'b0, lfsr_lo} + 3'd1) :
              etype == ET_REDEAD ? chase : (dir_q == DIR_DOWN ? DIR_UP : DIR_DOWN);
  end
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    hold_cnt_d = hold_cnt_q;
    dir_d      = dir_q;
    lfsr_step  = 1'b0;
    last_x_d   = fe ? Enemy_X : last_x_q;
    last_y_d   = fe ? Enemy_Y : last_y_q;
    if (room_chg) begin
      state_d    = S_INIT;
      init_cnt_d = '0;
      dir_d      = DIR_STOP;
    end else if (fe) begin
      if (state_q == S_INIT) begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = S_RUN;
          hold_cnt_d = HOLD_LAST;
        end
      end else if (!active || etype == ET_NONE) begin
        dir_d      = DIR_STOP;
        hold_cnt_d = HOLD_LAST;
      end else if (stall) begin
        dir_d      = reverse_dir(dir_q);
        hold_cnt_d = '0;
      end else if (hold_cnt_q == HOLD_LAST) begin
        dir_d      = pick;
        hold_cnt_d = '0;
        lfsr_step  = etype == ET_KEESE;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
    // The Enemy needs two frames to show motion after any new direction.
    guard_d      = dir_d != dir_q ? 2'd2 : (fe && guard_q != 2'd0) ? guard_q - 2'd1 : guard_q;
    initialize_d = state_d == S_INIT;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      dir_q        <= DIR_STOP;
      guard_q      <= 2'd0;
      initialize_q <= 1'b1;
      last_x_q     <= '0;
      last_y_q     <= '0;
      room_q       <= '0;
      room_vld_q   <= 1'b0;
      frame_clk_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      dir_q        <= dir_d;
      guard_q      <= guard_d;
      initialize_q <= initialize_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      room_q       <= room;
      room_vld_q   <= 1'b1;
      frame_clk_q  <= frame_clk;
    end
  assign dir        = dir_q;
  assign initialize = initialize_q;
endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// tb_enemy_ai_ctrl: directed and randomized checks of enemy_ai_ctrl against a frame-level model
module tb_enemy_ai_ctrl;
  localparam int HOLD = 32;
  localparam int INIT = 2;
  logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, active = 1'b1;
  logic [2:0] room = 3'd1;
  logic [1:0] Enemy_Type = 2'd0;
  logic [9:0] Enemy_X = 10'd300, Enemy_Y = 10'd200, Player_X = 10'd0, Player_Y = 10'd0;
  logic [2:0] dir;
  logic       initialize;
  int checks = 0, errors = 0;
  bit m_in_init;
  int m_init_left, m_dir, m_guard, m_wait, m_lx, m_ly;
  int unsigned m_lfsr;

  enemy_ai_ctrl #(.SEED(16'hACE1), .HOLD_FRAMES(HOLD), .INIT_FRAMES(INIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .room(room), .active(active),
    .Enemy_Type(Enemy_Type), .Enemy_X(Enemy_X), .Enemy_Y(Enemy_Y),
    .Player_X(Player_X), .Player_Y(Player_Y), .dir(dir), .initialize(initialize)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int rev(input int d);
    return d == 1 ? 2 : d == 2 ? 1 : d == 3 ? 4 : d == 4 ? 3 : 0;
  endfunction

  task automatic model_reset();
    m_in_init = 1; m_init_left = INIT; m_dir = 0; m_guard = 0; m_wait = 0;
    m_lx = 0; m_ly = 0; m_lfsr = 32'hACE1;
  endtask

  // m_wait counts frame edges still to go before the next pick
  task automatic model_step(input bit fe, input bit rc);
    int nd, dx, dy;
    nd = m_dir;
    if (rc) begin
      m_in_init = 1; m_init_left = INIT; nd = 0;
    end else if (fe) begin
      if (m_in_init) begin
        m_init_left--;
        if (m_init_left == 0) begin m_in_init = 0; m_wait = 0; end
      end else if (!active || Enemy_Type == 2'd0) begin
        nd = 0; m_wait = 0;
      end else if (m_guard == 0 && m_dir != 0 && Enemy_X == m_lx && Enemy_Y == m_ly) begin
        nd = rev(m_dir); m_wait = HOLD - 1;
      end else if (m_wait > 0) begin
        m_wait--;
      end else begin
        m_wait = HOLD - 1;
        case (Enemy_Type)
          2'd1: begin
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
            nd = int'(m_lfsr % 4) + 1;
          end
          2'd2: begin
            dx = int'(Player_X) - int'(Enemy_X);
            dy = int'(Player_Y) - int'(Enemy_Y);
            nd = (dx == 0 && dy == 0) ? 0 : (iabs(dx) >= iabs(dy)) ? (dx < 0 ? 1 : 2) : (dy < 0 ? 4 : 3);
          end
          default: nd = (m_dir == 3) ? 4 : 3;
        endcase
      end
    end
    if (nd != m_dir) m_guard = 2;
    else if (fe && m_guard > 0) m_guard--;
    m_dir = nd;
    if (fe) begin m_lx = Enemy_X; m_ly = Enemy_Y; end
  endtask

  task automatic frame();
    @(negedge Clk); frame_clk = 1'b1; model_step(1'b1, 1'b0);
    @(negedge Clk); frame_clk = 1'b0;
  endtask

  task automatic set_room(input logic [2:0] r, input bit with_fe);
    @(negedge Clk); room = r; frame_clk = with_fe; model_step(with_fe, 1'b1);
    @(negedge Clk); frame_clk = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset_n = 1'b0; model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    room = 3'd1; Enemy_Type = 2'd1; active = 1'b1; Enemy_X = 10'd300; Enemy_Y = 10'd200;
    @(negedge Clk); Reset_n = 1'b0; model_reset(); #1;
    checks++;
    if (initialize !== 1'b1 || dir !== 3'd0) begin
      errors++; $display("FAIL reset_state: init=%0b dir=%0d, need init=1 dir=0", initialize, dir);
    end
    @(negedge Clk); Reset_n = 1'b1; @(negedge Clk);
    for (int i = 1; i <= 3; i++) begin
      Enemy_X = Enemy_X + 10'd1;
      frame();
      checks++;
      if (initialize !== (i < 2)) begin
        errors++; $display("FAIL reset_init fe%0d: got %0b need %0b", i, initialize, i < 2);
      end
      checks++;
      if (dir !== ((i == 3) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL reset_dir fe%0d: got %0d need %0d", i, dir, (i == 3) ? 1 : 0);
      end
    end
    checks++;
    if (dut.u_lfsr.value !== 16'hE270) begin
      errors++; $display("FAIL first_lfsr: got %h need e270", dut.u_lfsr.value);
    end
  endtask

  task automatic test_keese_timer();
    for (int i = 1; i <= 40; i++) begin
      Enemy_X = Enemy_X + 10'd1;
      frame();
      checks++;
      if (dir !== 3'(m_dir) || dut.u_lfsr.value !== 16'(m_lfsr)) begin
        errors++; $display("FAIL keese fe%0d: dir=%0d lfsr=%h need dir=%0d lfsr=%h", i, dir, dut.u_lfsr.value, m_dir, 16'(m_lfsr));
      end
      if (i == 31 || i == 32) begin
        checks++;
        if (dut.u_lfsr.value !== ((i == 31) ? 16'hE270 : 16'h7138) || dir !== 3'd1) begin
          errors++; $display("FAIL keese_hold fe%0d: lfsr=%h dir=%0d", i, dut.u_lfsr.value, dir);
        end
      end
    end
  endtask

  task automatic test_redead();
    int ex[4] = '{300, 300, 300, 300};
    int ey[4] = '{200, 200, 200, 200};
    int px[4] = '{400, 300, 300, 250};
    int py[4] = '{100, 400, 200, 250};
    int ed[4] = '{2, 3, 0, 1};
    Enemy_Type = 2'd2;
    for (int k = 0; k < 12; k++) begin
      if (k < 4) begin
        Enemy_X = 10'(ex[k]); Enemy_Y = 10'(ey[k]); Player_X = 10'(px[k]); Player_Y = 10'(py[k]);
      end else begin
        Enemy_X = 10'($urandom_range(0, 1023)); Enemy_Y = 10'($urandom_range(0, 1023));
        Player_X = 10'($urandom_range(0, 1023)); Player_Y = 10'($urandom_range(0, 1023));
      end
      do_reset();
      repeat (3) frame();
      checks++;
      if (dir !== 3'(m_dir)) begin
        errors++; $display("FAIL redead_model case%0d: got %0d need %0d", k, dir, m_dir);
      end
      if (k < 4) begin
        checks++;
        if (dir !== 3'(ed[k])) begin
          errors++; $display("FAIL redead_dir case%0d: got %0d need %0d", k, dir, ed[k]);
        end
      end
    end
  endtask

  task automatic test_slider();
    int exp_s[4] = '{3, 4, 3, 4};
    Enemy_Type = 2'd3; Enemy_X = 10'd100; Enemy_Y = 10'd100;
    do_reset();
    for (int i = 1; i <= 99; i++) begin
      Enemy_Y = Enemy_Y + 10'd1;
      frame();
      checks++;
      if (dir !== 3'(m_dir)) begin
        errors++; $display("FAIL slider fe%0d: got %0d need %0d", i, dir, m_dir);
      end
      if (i >= 3 && (i - 3) % HOLD == 0) begin
        checks++;
        if (dir !== 3'(exp_s[(i - 3) / HOLD])) begin
          errors++; $display("FAIL slider_pick fe%0d: got %0d need %0d", i, dir, exp_s[(i - 3) / HOLD]);
        end
      end
    end
    for (int j = 1; j <= 4; j++) begin
      frame();
      checks++;
      if (dir !== ((j == 3 || j == 4) ? 3'd3 : 3'd4) || dir !== 3'(m_dir)) begin
        errors++; $display("FAIL slider_stall fe%0d: got %0d need %0d", j, dir, m_dir);
      end
    end
  endtask

  task automatic test_stall_reverse();
    Enemy_Type = 2'd2; Enemy_X = 10'd300; Enemy_Y = 10'd200; Player_X = 10'd400; Player_Y = 10'd200;
    do_reset();
    repeat (3) frame();
    checks++;
    if (dir !== 3'd2) begin
      errors++; $display("FAIL stall_setup: got %0d need 2", dir);
    end
    Enemy_Type = 2'd1;
    for (int j = 1; j <= 3; j++) begin
      frame();
      checks++;
      if (dir !== ((j < 3) ? 3'd2 : 3'd1) || dir !== 3'(m_dir)) begin
        errors++; $display("FAIL stall_rev fe%0d: got %0d need %0d", j, dir, (j < 3) ? 2 : 1);
      end
    end
    for (int j = 1; j <= 33; j++) begin
      Enemy_X = Enemy_X + 10'd1;
      frame();
      checks++;
      if (dir !== 3'(m_dir) || (j == 31 && dir !== 3'd1)) begin
        errors++; $display("FAIL stall_hold fe%0d: got %0d need %0d", j, dir, m_dir);
      end
    end
  endtask

  task automatic test_room_change();
    Enemy_Type = 2'd1; active = 1'b1; room = 3'd1;
    do_reset();
    repeat (3) begin Enemy_X = Enemy_X + 10'd1; frame(); end
    for (int k = 0; k < HOLD && m_wait != 0; k++) begin Enemy_X = Enemy_X + 10'd1; frame(); end
    set_room(3'd2, 1'b1);
    checks++;
    if (dir !== 3'd0 || initialize !== 1'b1 || dut.u_lfsr.value !== 16'hE270) begin
      errors++; $display("FAIL room_override: dir=%0d init=%0b lfsr=%h need 0 1 e270", dir, initialize, dut.u_lfsr.value);
    end
    for (int i = 1; i <= 3; i++) begin
      Enemy_X = Enemy_X + 10'd1;
      frame();
      checks++;
      if (initialize !== (i < 2) || dir !== 3'(m_dir)) begin
        errors++; $display("FAIL room_init fe%0d: init=%0b dir=%0d need %0b %0d", i, initialize, dir, i < 2, m_dir);
      end
    end
    active = 1'b0; Enemy_X = Enemy_X + 10'd1; frame();
    checks++;
    if (dir !== 3'd0) begin
      errors++; $display("FAIL inactive_stop: got %0d need 0", dir);
    end
    active = 1'b1; Enemy_X = Enemy_X + 10'd1; frame();
    set_room(3'd3, 1'b0);
    checks++;
    if (dir !== 3'd0 || initialize !== 1'b1) begin
      errors++; $display("FAIL room_nofe: dir=%0d init=%0b need 0 1", dir, initialize);
    end
    frame();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      Enemy_X = Enemy_X + 10'd1;
      frame();
      checks++;
      if (initialize !== (i < 2) || dir !== 3'(m_dir)) begin
        errors++; $display("FAIL reset_mid_init fe%0d: init=%0b dir=%0d need %0b %0d", i, initialize, dir, i < 2, m_dir);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) Enemy_Type = 2'($urandom_range(0, 3));
      active = $urandom_range(0, 11) != 0;
      if ($urandom_range(0, 3) != 0) Enemy_X = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) != 0) Enemy_Y = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) begin
        Player_X = 10'($urandom_range(0, 1023)); Player_Y = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 39) == 0) set_room(room + 3'd1, 1'($urandom_range(0, 1)));
      else frame();
      checks++;
      if (dir !== 3'(m_dir) || initialize !== m_in_init || dut.u_lfsr.value !== 16'(m_lfsr)) begin
        errors++; $display("FAIL random step%0d: dir=%0d init=%0b lfsr=%h need %0d %0b %h",
                           i, dir, initialize, dut.u_lfsr.value, m_dir, m_in_init, 16'(m_lfsr));
      end
    end
  endtask

  initial begin
    test_reset();
    test_keese_timer();
    test_redead();
    test_slider();
    test_stall_reverse();
    test_room_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
